// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Iteration counter must hold WIDTH itself (counts WIDTH down to 0).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ovf_check.sv
// Mode-dependent overflow test for a full 2*WIDTH-bit product.
module ovf_check
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] product,
    input  logic               signed_mode,
    input  logic               zero_op,
    output logic               overflow
);

    logic [2*WIDTH-1:0] fit_signed;
    logic [2*WIDTH-1:0] fit_unsigned;

    // The product fits in WIDTH bits exactly when it equals the extension of its low word.
    assign fit_signed   = {{WIDTH{product[WIDTH-1]}}, product[WIDTH-1:0]};
    assign fit_unsigned = {{WIDTH{1'b0}}, product[WIDTH-1:0]};

    always_comb begin
        overflow = 1'b0;
        if (!zero_op) begin
            if (signed_mode) overflow = (product != fit_signed);
            else             overflow = (product != fit_unsigned);
        end
    end

endmodule

// File: rtl/seq_mult_ovf.sv
// Radix-2 Booth sequential multiplier with start/ready handshake, zero-operand
// fast path and registered low/high product words plus overflow flag.
module seq_mult_ovf
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] product_hi,
    output logic             overflow,
    output logic             result_valid
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = WIDTH + 1;

    state_t              state, state_next;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       mcand;
    logic [AW-1:0]       acc_hi;
    logic [AW-1:0]       acc_lo;
    logic                q_m1;
    logic                mode_q;
    logic                zero_q;

    logic                accept;
    logic                zero_in;
    logic [AW-1:0]       a_ext;
    logic [AW-1:0]       b_ext;
    logic [AW-1:0]       sum;
    logic [2*WIDTH-1:0]  product;
    logic                ovf;

    assign ready   = (state == IDLE) && !reset;
    assign accept  = start && ready;
    assign zero_in = (op_a == '0) || (op_b == '0);
    assign a_ext   = {signed_mode & op_a[WIDTH-1], op_a};
    assign b_ext   = {signed_mode & op_b[WIDTH-1], op_b};

    // Booth recoding of the multiplier LSB pair selects add, subtract or pass.
    always_comb begin
        sum = acc_hi;
        case ({acc_lo[0], q_m1})
            2'b01:   sum = acc_hi + mcand;
            2'b10:   sum = acc_hi - mcand;
            default: sum = acc_hi;
        endcase
    end

    // Low 2*WIDTH bits of the accumulator after this step's arithmetic shift.
    assign product = {sum[WIDTH-1:0], acc_lo[AW-1:1]};

    ovf_check #(.WIDTH(WIDTH)) u_ovf_check (
        .product     (product),
        .signed_mode (mode_q),
        .zero_op     (zero_q),
        .overflow    (ovf)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = zero_in ? DONE : RUN;
            RUN:  if (cnt == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand/accumulator registers carry no reset; they are always loaded at accept before use.
    always_ff @(posedge clock) begin
        if (accept) begin
            mcand  <= a_ext;
            acc_hi <= '0;
            acc_lo <= b_ext;
            q_m1   <= 1'b0;
            mode_q <= signed_mode;
            zero_q <= zero_in;
        end else if (state == RUN) begin
            acc_hi <= {sum[AW-1], sum[AW-1:1]};
            acc_lo <= {sum[0], acc_lo[AW-1:1]};
            q_m1   <= acc_lo[0];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            result       <= '0;
            product_hi   <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= 1'b0;
            case (state)
                IDLE: if (accept) cnt <= CW'(WIDTH);
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        result       <= product[WIDTH-1:0];
                        product_hi   <= product[2*WIDTH-1:WIDTH];
                        overflow     <= ovf;
                        result_valid <= 1'b1;
                    end
                end
                DONE: if (zero_q) begin
                    result       <= '0;
                    product_hi   <= '0;
                    overflow     <= ovf;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ovf.sv
// Directed self-checking bench for seq_mult_ovf at WIDTH=32.
module tb_seq_mult_ovf;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic [W-1:0] result;
    logic [W-1:0] product_hi;
    logic         overflow;
    logic         result_valid;

    int checks = 0;
    int errors = 0;

    seq_mult_ovf #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .op_a         (op_a),
        .op_b         (op_b),
        .ready        (ready),
        .result       (result),
        .product_hi   (product_hi),
        .overflow     (overflow),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            if (ready === 1'b1) return;
            @(negedge clock);
        end
        checks++;
        errors++;
        $display("FAIL wait_ready: ready=%b required 1 within 100 cycles", ready);
    endtask

    // Accepts one operation at E0 and returns the edge index of the valid pulse.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          output int lat, output logic [W-1:0] r, output logic [W-1:0] h,
                          output logic o);
        @(negedge clock);
        wait_ready();
        op_a = a; op_b = b; signed_mode = m; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; op_a = ~a; op_b = ~b; signed_mode = ~m;
        lat = -1; r = '0; h = '0; o = 1'b0;
        for (int k = 1; k <= W + 10; k++) begin
            @(posedge clock);
            #1;
            if (result_valid === 1'b1) begin
                lat = k; r = result; h = product_hi; o = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; signed_mode = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        checks++; if ({result, product_hi, overflow} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h %h %b want all 0", result, product_hi, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ready); end
    endtask

    task automatic test_timing_and_hold();
        int lat; logic [W-1:0] r, h; logic o;
        run_op(32'h0001_0000, 32'h0001_0000, 1'b1, lat, r, h, o);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL big_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (r !== 32'h0 || h !== 32'h1 || o !== 1'b1) begin
            errors++; $display("FAIL big_product: got %h %h %b want 00000000 00000001 1", r, h, o);
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b want 0", ready); end
        @(posedge clock);
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", result_valid); end
        checks++; if (result !== 32'h0 || product_hi !== 32'h1 || overflow !== 1'b1) begin
            errors++; $display("FAIL hold: got %h %h %b want 00000000 00000001 1", result, product_hi, overflow);
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready); end
    endtask

    task automatic test_product(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic m, input logic [W-1:0] er, input logic [W-1:0] eh,
                                input logic eo);
        int lat; logic [W-1:0] r, h; logic o;
        run_op(a, b, m, lat, r, h, o);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1); end
        checks++; if (r !== er || h !== eh || o !== eo) begin
            errors++; $display("FAIL %s: got %h %h %b want %h %h %b", name, r, h, o, er, eh, eo);
        end
    endtask

    task automatic test_fast_path();
        @(negedge clock);
        wait_ready();
        op_a = '0; op_b = 32'h7FFF_FFFF; signed_mode = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        checks++; if (result_valid !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL fast_e0: got valid=%b ready=%b want 0 0", result_valid, ready);
        end
        @(posedge clock); #1;
        checks++; if (result_valid !== 1'b1 || result !== 32'h0 || product_hi !== 32'h0 || overflow !== 1'b0) begin
            errors++; $display("FAIL fast_e1: got valid=%b %h %h %b want 1 00000000 00000000 0",
                               result_valid, result, product_hi, overflow);
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fast_e1_ready: got %b want 1", ready); end
        @(posedge clock); #1;
        checks++; if (result_valid !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL fast_e2_reaccept: got valid=%b ready=%b want 0 0", result_valid, ready);
        end
        @(posedge clock); #1;
        checks++; if (result_valid !== 1'b1 || result !== 32'h0) begin
            errors++; $display("FAIL fast_e3: got valid=%b result=%h want 1 00000000", result_valid, result);
        end
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL fast_e5: got valid=%b want 1", result_valid); end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        @(negedge clock);
        wait_ready();
        op_a = 32'h1234_5678; op_b = 32'h0000_0009; signed_mode = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset: got %b want 0", ready); end
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++; if ({result, product_hi, overflow, result_valid} !== '0) begin
            errors++; $display("FAIL abort_clear: got %h %h %b %b want all 0", result, product_hi, overflow, result_valid);
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (result_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d pulses want 0", seen); end
        test_product("after_abort_3x5", 32'h3, 32'h5, 1'b1, 32'h0000_000F, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_timing_and_hold();
        test_product("signed_neg3x7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        test_product("unsigned_ffx2", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        test_fast_path();
        test_product("signed_ffx2", 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        test_product("signed_minxneg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1);
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
